// File: rtl/cpu_operand_fetch_pkg.sv
// rtl/cpu_operand_fetch_pkg.sv - shared widths, types and counter helper for operand fetch
package cpu_operand_fetch_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = $clog2(NUM_REGS);
    localparam int PEND_W   = 2;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [XLEN-1:0]   word_t;
    typedef logic [PEND_W-1:0] pend_t;

    localparam pend_t PEND_MAX = '1;

    typedef struct packed {
        word_t    data_a;
        word_t    data_b;
        logic     rd_we;
        reg_idx_t rd;
    } fetch_out_t;

    // Net counter update; decrements beyond zero clamp so a stray writeback cannot underflow.
    function automatic pend_t pend_next(input pend_t cur, input logic inc, input logic [1:0] dec);
        logic [PEND_W:0] up;
        logic [PEND_W:0] dn;
        up = {1'b0, cur} + {{PEND_W{1'b0}}, inc};
        dn = (PEND_W+1)'(dec);
        if (up <= dn)
            return '0;
        return pend_t'(up - dn);
    endfunction

endpackage

// File: rtl/cpu_operand_fetch_if.sv
// rtl/cpu_operand_fetch_if.sv - pipeline-side and register-bank-side interfaces
interface cpu_operand_fetch_if;
    import cpu_operand_fetch_pkg::*;

    logic     in_valid;
    logic     in_ready;
    logic     in_use_a;
    logic     in_use_b;
    reg_idx_t in_rs_a;
    reg_idx_t in_rs_b;
    logic     in_rd_we;
    reg_idx_t in_rd;
    logic     out_valid;
    logic     out_ready;
    word_t    out_data_a;
    word_t    out_data_b;
    logic     out_rd_we;
    reg_idx_t out_rd;
    logic     flush;
    logic     wb_valid;
    reg_idx_t wb_reg;
    word_t    wb_data;

    modport master (
        output in_valid, in_use_a, in_use_b, in_rs_a, in_rs_b, in_rd_we, in_rd,
        output out_ready, flush, wb_valid, wb_reg, wb_data,
        input  in_ready, out_valid, out_data_a, out_data_b, out_rd_we, out_rd
    );

    modport slave (
        input  in_valid, in_use_a, in_use_b, in_rs_a, in_rs_b, in_rd_we, in_rd,
        input  out_ready, flush, wb_valid, wb_reg, wb_data,
        output in_ready, out_valid, out_data_a, out_data_b, out_rd_we, out_rd
    );
endinterface

interface cpu_bank_reg_if;
    import cpu_operand_fetch_pkg::*;

    reg_idx_t read_reg_a;
    reg_idx_t read_reg_b;
    word_t    read_data_a;
    word_t    read_data_b;
    logic     write_enable;
    reg_idx_t write_reg;
    word_t    write_data;

    modport master (
        output read_reg_a, read_reg_b, write_enable, write_reg, write_data,
        input  read_data_a, read_data_b
    );

    modport slave (
        input  read_reg_a, read_reg_b, write_enable, write_reg, write_data,
        output read_data_a, read_data_b
    );
endinterface

// File: rtl/cpu_operand_fetch_scoreboard.sv
// rtl/cpu_operand_fetch_scoreboard.sv - per-register pending-write counters
module cpu_operand_fetch_scoreboard
    import cpu_operand_fetch_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     i_inc_en,
    input  reg_idx_t i_inc_reg,
    input  logic     i_wb_en,
    input  reg_idx_t i_wb_reg,
    input  logic     i_fl_en,
    input  reg_idx_t i_fl_reg,
    input  reg_idx_t i_rs_a,
    input  reg_idx_t i_rs_b,
    input  reg_idx_t i_rd,
    output pend_t    o_pend_a,
    output pend_t    o_pend_b,
    output pend_t    o_pend_rd
);

    pend_t r_pend      [NUM_REGS];
    pend_t w_pend_next [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_pend_next[i] = pend_next(
                r_pend[i],
                i_inc_en && (i_inc_reg == reg_idx_t'(i)),
                {1'b0, i_wb_en && (i_wb_reg == reg_idx_t'(i))} +
                {1'b0, i_fl_en && (i_fl_reg == reg_idx_t'(i))});
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_pend[i] <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign o_pend_a  = r_pend[i_rs_a];
    assign o_pend_b  = r_pend[i_rs_b];
    assign o_pend_rd = r_pend[i_rd];

endmodule

// File: rtl/cpu_operand_fetch.sv
// rtl/cpu_operand_fetch.sv - operand fetch with writeback bypass, RAW stall and 1-entry output register
module cpu_operand_fetch
    import cpu_operand_fetch_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    cpu_operand_fetch_if.slave   pipe,
    cpu_bank_reg_if.master       bank
);

    pend_t      w_pend_a;
    pend_t      w_pend_b;
    pend_t      w_pend_rd;
    logic       w_wb_hit_a;
    logic       w_wb_hit_b;
    logic       w_wb_hit_rd;
    logic       w_hazard_a;
    logic       w_hazard_b;
    logic       w_full_rd;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_flush_dec;
    word_t      w_opnd_a;
    word_t      w_opnd_b;
    logic       r_out_valid;
    fetch_out_t r_out;

    assign bank.read_reg_a   = pipe.in_rs_a;
    assign bank.read_reg_b   = pipe.in_rs_b;
    assign bank.write_enable = pipe.wb_valid;
    assign bank.write_reg    = pipe.wb_reg;
    assign bank.write_data   = pipe.wb_data;

    assign w_wb_hit_a  = pipe.wb_valid && (pipe.wb_reg == pipe.in_rs_a);
    assign w_wb_hit_b  = pipe.wb_valid && (pipe.wb_reg == pipe.in_rs_b);
    assign w_wb_hit_rd = pipe.wb_valid && (pipe.wb_reg == pipe.in_rd);

    // The bank write lands on the edge, so a same-cycle read would see the stale value.
    assign w_opnd_a = !pipe.in_use_a ? '0 : (w_wb_hit_a ? pipe.wb_data : bank.read_data_a);
    assign w_opnd_b = !pipe.in_use_b ? '0 : (w_wb_hit_b ? pipe.wb_data : bank.read_data_b);

    assign w_hazard_a = pipe.in_use_a && (w_pend_a != '0) &&
                        !((w_pend_a == pend_t'(1)) && w_wb_hit_a);
    assign w_hazard_b = pipe.in_use_b && (w_pend_b != '0) &&
                        !((w_pend_b == pend_t'(1)) && w_wb_hit_b);
    assign w_full_rd  = pipe.in_rd_we && (w_pend_rd == PEND_MAX) && !w_wb_hit_rd;

    assign w_in_ready  = (!r_out_valid || pipe.out_ready) && !w_hazard_a && !w_hazard_b &&
                         !w_full_rd && !pipe.flush;
    assign w_accept    = pipe.in_valid && w_in_ready;
    assign w_flush_dec = pipe.flush && r_out_valid && r_out.rd_we;

    cpu_operand_fetch_scoreboard u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .i_inc_en  (w_accept && pipe.in_rd_we),
        .i_inc_reg (pipe.in_rd),
        .i_wb_en   (pipe.wb_valid),
        .i_wb_reg  (pipe.wb_reg),
        .i_fl_en   (w_flush_dec),
        .i_fl_reg  (r_out.rd),
        .i_rs_a    (pipe.in_rs_a),
        .i_rs_b    (pipe.in_rs_b),
        .i_rd      (pipe.in_rd),
        .o_pend_a  (w_pend_a),
        .o_pend_b  (w_pend_b),
        .o_pend_rd (w_pend_rd)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (pipe.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= '{data_a: w_opnd_a, data_b: w_opnd_b,
                             rd_we: pipe.in_rd_we, rd: pipe.in_rd};
        end else if (pipe.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign pipe.in_ready   = w_in_ready;
    assign pipe.out_valid  = r_out_valid;
    assign pipe.out_data_a = r_out.data_a;
    assign pipe.out_data_b = r_out.data_b;
    assign pipe.out_rd_we  = r_out.rd_we;
    assign pipe.out_rd     = r_out.rd;

endmodule

// File: tb/tb_cpu_operand_fetch.sv
// tb/tb_cpu_operand_fetch.sv - scoreboard bench for cpu_operand_fetch with a behavioural bank
module tb_cpu_operand_fetch;
    import cpu_operand_fetch_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic init_bank = 1'b1;
    int   checks = 0;
    int   failures = 0;

    fetch_out_t exp_q [$];
    word_t      bank_mem [NUM_REGS];

    cpu_operand_fetch_if pipe_if ();
    cpu_bank_reg_if      bank_if ();

    cpu_operand_fetch dut (
        .clock (clock),
        .reset (reset),
        .pipe  (pipe_if),
        .bank  (bank_if)
    );

    always #5 clock = ~clock;

    // Bank preload: register i holds 0xA000_0000 + i until written.
    always @(posedge clock) begin
        if (init_bank) begin
            for (int i = 0; i < NUM_REGS; i++)
                bank_mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (bank_if.write_enable) begin
            bank_mem[bank_if.write_reg] <= bank_if.write_data;
        end
    end

    assign bank_if.read_data_a = bank_mem[bank_if.read_reg_a];
    assign bank_if.read_data_b = bank_mem[bank_if.read_reg_b];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ua, input reg_idx_t ra, input logic ub, input reg_idx_t rb,
                         input logic we, input reg_idx_t rd);
        pipe_if.in_valid = 1'b1;
        pipe_if.in_use_a = ua;
        pipe_if.in_rs_a  = ra;
        pipe_if.in_use_b = ub;
        pipe_if.in_rs_b  = rb;
        pipe_if.in_rd_we = we;
        pipe_if.in_rd    = rd;
    endtask

    task automatic push_exp(input word_t a, input word_t b, input logic we, input reg_idx_t rd);
        exp_q.push_back('{data_a: a, data_b: b, rd_we: we, rd: rd});
    endtask

    task automatic set_wb(input logic v, input reg_idx_t r, input word_t d);
        pipe_if.wb_valid = v;
        pipe_if.wb_reg   = r;
        pipe_if.wb_data  = d;
    endtask

    // Monitor: every output handshake consumes the oldest expected entry.
    initial begin
        fetch_out_t e;
        forever begin
            @(negedge clock);
            if (!reset && pipe_if.out_valid && pipe_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h expected=none", pipe_if.out_data_a);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data_a", pipe_if.out_data_a, e.data_a);
                    chk("out_data_b", pipe_if.out_data_b, e.data_b);
                    chk("out_rd_we_rd", 32'({pipe_if.out_rd_we, pipe_if.out_rd}), 32'({e.rd_we, e.rd}));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        pipe_if.in_valid  = 1'b0;
        pipe_if.out_ready = 1'b1;
        pipe_if.flush     = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
        pipe_if.in_valid  = 1'b0;
        set_wb(1'b0, '0, '0);
        step();
        init_bank = 1'b0;
        step();
        step();
        reset = 1'b0;

        @(negedge clock);
        chk("rst_out_valid", 32'(pipe_if.out_valid), 32'd0);
        chk("rst_out_data_a", pipe_if.out_data_a, 32'd0);
        chk("rst_out_data_b", pipe_if.out_data_b, 32'd0);
        chk("rst_out_rd", 32'({pipe_if.out_rd_we, pipe_if.out_rd}), 32'd0);
        chk("rst_in_ready", 32'(pipe_if.in_ready), 32'd1);
        step();

        // Writeback then read the written register.
        set_wb(1'b1, 5'd2, 32'h2);
        step();
        set_wb(1'b0, '0, '0);
        drive(1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        push_exp(32'h2, 32'h0, 1'b0, 5'd0);
        @(negedge clock);
        chk("t1_in_ready", 32'(pipe_if.in_ready), 32'd1);
        step();
        pipe_if.in_valid = 1'b0;
        @(negedge clock);
        chk("t1_out_valid", 32'(pipe_if.out_valid), 32'd1);
        step();

        // Same-cycle bypass on B, plain bank read on A.
        set_wb(1'b1, 5'd1, 32'h14);
        drive(1'b1, 5'd6, 1'b1, 5'd1, 1'b0, 5'd0);
        push_exp(32'hA000_0006, 32'h14, 1'b0, 5'd0);
        @(negedge clock);
        chk("t2_in_ready", 32'(pipe_if.in_ready), 32'd1);
        step();
        pipe_if.in_valid = 1'b0;
        set_wb(1'b0, '0, '0);
        step();

        // RAW stall until writeback of r3.
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        push_exp(32'h0, 32'h0, 1'b1, 5'd3);
        @(negedge clock);
        chk("t3_prod_ready", 32'(pipe_if.in_ready), 32'd1);
        step();
        drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk("t3_stall_ready", 32'(pipe_if.in_ready), 32'd0);
            step();
        end
        set_wb(1'b1, 5'd3, 32'h55);
        push_exp(32'h55, 32'h0, 1'b0, 5'd0);
        @(negedge clock);
        chk("t3_wb_ready", 32'(pipe_if.in_ready), 32'd1);
        step();
        pipe_if.in_valid = 1'b0;
        set_wb(1'b0, '0, '0);
        step();

        // Backpressure: held output stays stable, next instruction waits.
        pipe_if.out_ready = 1'b0;
        drive(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd9);
        push_exp(32'hA000_0008, 32'h0, 1'b1, 5'd9);
        @(negedge clock);
        chk("t4_first_ready", 32'(pipe_if.in_ready), 32'd1);
        step();
        drive(1'b0, 5'd0, 1'b1, 5'd10, 1'b0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("t4_bp_ready", 32'(pipe_if.in_ready), 32'd0);
            chk("t4_bp_valid", 32'(pipe_if.out_valid), 32'd1);
            chk("t4_bp_data_a", pipe_if.out_data_a, 32'hA000_0008);
            chk("t4_bp_rd", 32'(pipe_if.out_rd), 32'd9);
            step();
        end
        pipe_if.out_ready = 1'b1;
        push_exp(32'h0, 32'hA000_000A, 1'b0, 5'd0);
        @(negedge clock);
        chk("t4_drain_ready", 32'(pipe_if.in_ready), 32'd1);
        step();
        pipe_if.in_valid = 1'b0;
        step();

        // Pending limit on r5: three in flight, fourth waits for a writeback.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5);
            push_exp(32'h0, 32'h0, 1'b1, 5'd5);
            @(negedge clock);
            chk("t5_fill_ready", 32'(pipe_if.in_ready), 32'd1);
            step();
        end
        @(negedge clock);
        chk("t5_full_ready", 32'(pipe_if.in_ready), 32'd0);
        step();
        set_wb(1'b1, 5'd5, 32'h5A);
        push_exp(32'h0, 32'h0, 1'b1, 5'd5);
        @(negedge clock);
        chk("t5_wb_ready", 32'(pipe_if.in_ready), 32'd1);
        step();
        pipe_if.in_valid = 1'b0;
        set_wb(1'b0, '0, '0);
        step();

        // Flush a held writer of r7; r7 must then be free to read.
        pipe_if.out_ready = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
        push_exp(32'h0, 32'h0, 1'b1, 5'd7);
        @(negedge clock);
        chk("t6_hold_ready", 32'(pipe_if.in_ready), 32'd1);
        step();
        pipe_if.in_valid = 1'b0;
        pipe_if.flush = 1'b1;
        @(negedge clock);
        chk("t6_flush_ready", 32'(pipe_if.in_ready), 32'd0);
        chk("t6_pre_valid", 32'(pipe_if.out_valid), 32'd1);
        step();
        pipe_if.flush = 1'b0;
        void'(exp_q.pop_back());
        pipe_if.out_ready = 1'b1;
        drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
        push_exp(32'hA000_0007, 32'h0, 1'b0, 5'd0);
        @(negedge clock);
        chk("t6_post_valid", 32'(pipe_if.out_valid), 32'd0);
        chk("t6_r7_free", 32'(pipe_if.in_ready), 32'd1);
        step();
        pipe_if.in_valid = 1'b0;
        step();

        // Reset mid-stall: r9 pending and r5 full; late wb still reaches the bank.
        drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd5);
        @(negedge clock);
        chk("t7_pre_ready", 32'(pipe_if.in_ready), 32'd0);
        step();
        reset = 1'b1;
        exp_q.delete();
        set_wb(1'b1, 5'd11, 32'hBEEF);
        step();
        set_wb(1'b0, '0, '0);
        reset = 1'b0;
        push_exp(32'hA000_0009, 32'h0, 1'b1, 5'd5);
        @(negedge clock);
        chk("t7_post_ready", 32'(pipe_if.in_ready), 32'd1);
        chk("t7_post_valid", 32'(pipe_if.out_valid), 32'd0);
        step();
        drive(1'b1, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0);
        push_exp(32'hBEEF, 32'h0, 1'b0, 5'd0);
        @(negedge clock);
        chk("t7_late_wb_ready", 32'(pipe_if.in_ready), 32'd1);
        step();
        pipe_if.in_valid = 1'b0;
        step();
        step();

        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
